// File: rtl/multi_buffer.sv
// N-bank frame store for the life engine: logic reads the current bank, writes the write bank,
// the renderer reads a display bank that only moves on a frame pulse; swaps optionally clear the new write bank.
module multi_buffer #(
  parameter int unsigned WORD_SIZE     = 16,
  parameter int unsigned DEPTH         = 4096,
  parameter int unsigned NUM_BANKS     = 3,
  parameter int unsigned CLEAR_ON_SWAP = 1,
  localparam int unsigned AW           = $clog2(DEPTH),
  localparam int unsigned BW           = $clog2(NUM_BANKS)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 swap_req_in,
  output logic                 swap_ack_out,
  input  logic                 render_frame_in,
  input  logic [AW-1:0]        render_addr_r,
  input  logic [AW-1:0]        logic_addr_r,
  input  logic [AW-1:0]        logic_addr_w,
  input  logic [WORD_SIZE-1:0] logic_data_w,
  input  logic                 logic_wr_en,
  output logic                 ready_out,
  output logic [WORD_SIZE-1:0] render_data_r,
  output logic [WORD_SIZE-1:0] logic_data_r,
  output logic [BW-1:0]        cur_bank_out,
  output logic [BW-1:0]        disp_bank_out
);

  if (NUM_BANKS < 3) begin : g_bank_check
    $error("multi_buffer: NUM_BANKS must be at least 3");
  end

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        clr_q, clr_d;
  logic [BW-1:0]        cur_q, cur_d;
  logic [BW-1:0]        wr_q, wr_d;
  logic [BW-1:0]        disp_q, disp_d;
  logic                 ready_q, ready_d;
  logic [BW-1:0]        rsel_render_q, rsel_render_d;
  logic [BW-1:0]        rsel_logic_q, rsel_logic_d;
  logic [WORD_SIZE-1:0] render_data_q, render_data_d;
  logic [WORD_SIZE-1:0] logic_data_q, logic_data_d;

  logic                 swap_acc;
  logic [BW-1:0]        disp_next;
  logic [BW-1:0]        wr_pick;
  logic                 pick_found;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [WORD_SIZE-1:0] mem_wdata;

  logic [WORD_SIZE-1:0] ram_render [NUM_BANKS];
  logic [WORD_SIZE-1:0] ram_logic  [NUM_BANKS];

  // ready_q mirrors IDLE but stays low for the first cycle out of reset
  assign swap_acc = ready_q && swap_req_in;

  // Lowest bank that is neither the outgoing write bank nor the display bank after this cycle
  always_comb begin
    disp_next  = render_frame_in ? cur_q : disp_q;
    wr_pick    = '0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (!pick_found && (BW'(i) != wr_q) && (BW'(i) != disp_next)) begin
        wr_pick    = BW'(i);
        pick_found = 1'b1;
      end
    end
  end

  // Next-state, bank rotation and write-port steering
  always_comb begin
    state_d       = state_q;
    clr_d         = clr_q;
    cur_d         = cur_q;
    wr_d          = wr_q;
    disp_d        = disp_next;
    mem_we        = 1'b0;
    mem_waddr     = logic_addr_w;
    mem_wdata     = logic_data_w;
    rsel_render_d = disp_q;
    rsel_logic_d  = cur_q;
    render_data_d = ram_render[rsel_render_q];
    logic_data_d  = ram_logic[rsel_logic_q];

    case (state_q)
      IDLE: begin
        mem_we = logic_wr_en;
        if (swap_acc) begin
          cur_d = wr_q;
          wr_d  = wr_pick;
          if (CLEAR_ON_SWAP != 0) begin
            state_d = CLEAR;
            clr_d   = '0;
          end
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = '0;
        clr_d     = clr_q + AW'(1);
        if (clr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          clr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      clr_q         <= '0;
      cur_q         <= '0;
      wr_q          <= BW'(1);
      disp_q        <= '0;
      ready_q       <= 1'b0;
      rsel_render_q <= '0;
      rsel_logic_q  <= '0;
      render_data_q <= '0;
      logic_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      clr_q         <= clr_d;
      cur_q         <= cur_d;
      wr_q          <= wr_d;
      disp_q        <= disp_d;
      ready_q       <= ready_d;
      rsel_render_q <= rsel_render_d;
      rsel_logic_q  <= rsel_logic_d;
      render_data_q <= render_data_d;
      logic_data_q  <= logic_data_d;
    end
  end

  // One RAM per bank: single write port, two synchronous read ports, contents not reset
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [WORD_SIZE-1:0] rd_render_q;
    logic [WORD_SIZE-1:0] rd_logic_q;

    always_ff @(posedge clk_in) begin
      if (mem_we && (wr_q == BW'(b))) begin
        mem[mem_waddr] <= mem_wdata;
      end
      rd_render_q <= mem[render_addr_r];
      rd_logic_q  <= mem[logic_addr_r];
    end

    assign ram_render[b] = rd_render_q;
    assign ram_logic[b]  = rd_logic_q;
  end

  assign swap_ack_out  = swap_acc;
  assign ready_out     = ready_q;
  assign render_data_r = render_data_q;
  assign logic_data_r  = logic_data_q;
  assign cur_bank_out  = cur_q;
  assign disp_bank_out = disp_q;

endmodule

// File: tb/tb_multi_buffer.sv
// Directed bench for multi_buffer: 3 banks, 16-word banks, clear-on-swap enabled.
module tb_multi_buffer;

  localparam int unsigned WS  = 16;
  localparam int unsigned DEP = 16;
  localparam int unsigned NB  = 3;
  localparam int unsigned AW  = $clog2(DEP);
  localparam int unsigned BW  = $clog2(NB);

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          swap_req_in = 1'b0;
  logic          swap_ack_out;
  logic          render_frame_in = 1'b0;
  logic [AW-1:0] render_addr_r = '0;
  logic [AW-1:0] logic_addr_r = '0;
  logic [AW-1:0] logic_addr_w = '0;
  logic [WS-1:0] logic_data_w = '0;
  logic          logic_wr_en = 1'b0;
  logic          ready_out;
  logic [WS-1:0] render_data_r;
  logic [WS-1:0] logic_data_r;
  logic [BW-1:0] cur_bank_out;
  logic [BW-1:0] disp_bank_out;

  int errors = 0;
  int checks = 0;

  multi_buffer #(
    .WORD_SIZE(WS), .DEPTH(DEP), .NUM_BANKS(NB), .CLEAR_ON_SWAP(1)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .swap_req_in(swap_req_in), .swap_ack_out(swap_ack_out),
    .render_frame_in(render_frame_in),
    .render_addr_r(render_addr_r), .logic_addr_r(logic_addr_r),
    .logic_addr_w(logic_addr_w), .logic_data_w(logic_data_w), .logic_wr_en(logic_wr_en),
    .ready_out(ready_out), .render_data_r(render_data_r), .logic_data_r(logic_data_r),
    .cur_bank_out(cur_bank_out), .disp_bank_out(disp_bank_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [WS-1:0] d);
    logic_addr_w = a;
    logic_data_w = d;
    logic_wr_en  = 1'b1;
    tick();
    logic_wr_en  = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready_out && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: ready_out=%0b after %0d cycles, expected 1", ready_out, n);
    end
  endtask

  task automatic do_swap();
    int n;
    swap_req_in = 1'b1;
    #1;
    n = 0;
    while (!swap_ack_out && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (swap_ack_out !== 1'b1) begin
      errors++;
      $display("FAIL do_swap_ack: swap_ack_out=%0b, expected 1", swap_ack_out);
    end
    tick();
    swap_req_in = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n_in = 1'b0;
    swap_req_in = 1'b0;
    render_frame_in = 1'b0;
    logic_wr_en = 1'b0;
    tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", ready_out); end
    checks++; if (swap_ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", swap_ack_out); end
    checks++; if (cur_bank_out !== 2'd0) begin errors++; $display("FAIL reset_cur: got %0d expected 0", cur_bank_out); end
    checks++; if (disp_bank_out !== 2'd0) begin errors++; $display("FAIL reset_disp: got %0d expected 0", disp_bank_out); end
    checks++; if (logic_data_r !== 16'h0) begin errors++; $display("FAIL reset_logic_data: got %h expected 0000", logic_data_r); end
    checks++; if (render_data_r !== 16'h0) begin errors++; $display("FAIL reset_render_data: got %h expected 0000", render_data_r); end
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    #1;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %0b expected 0", ready_out); end
    tick();
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_first_clock_ready: got %0b expected 1", ready_out); end
  endtask

  task automatic test_write_swap();
    write_word(4'd5, 16'hBEEF);
    swap_req_in = 1'b1;
    #1;
    checks++; if (swap_ack_out !== 1'b1) begin errors++; $display("FAIL ws_ack: got %0b expected 1", swap_ack_out); end
    tick();
    swap_req_in = 1'b0;
    #1;
    checks++; if (swap_ack_out !== 1'b0) begin errors++; $display("FAIL ws_ack_pulse: got %0b expected 0", swap_ack_out); end
    checks++; if (cur_bank_out !== 2'd1) begin errors++; $display("FAIL ws_cur: got %0d expected 1", cur_bank_out); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL ws_ready_clear: got %0b expected 0", ready_out); end
    logic_addr_r  = 4'd5;
    render_addr_r = 4'd5;
    tick();
    tick();
    checks++; if (logic_data_r !== 16'hBEEF) begin errors++; $display("FAIL ws_logic_read: got %h expected beef", logic_data_r); end
    checks++; if (render_data_r === 16'hBEEF) begin errors++; $display("FAIL ws_render_pre_frame: got %h expected bank 0 data, not beef", render_data_r); end
    render_frame_in = 1'b1;
    tick();
    render_frame_in = 1'b0;
    checks++; if (disp_bank_out !== 2'd1) begin errors++; $display("FAIL ws_disp: got %0d expected 1", disp_bank_out); end
    tick();
    tick();
    checks++; if (render_data_r !== 16'hBEEF) begin errors++; $display("FAIL ws_render_post_frame: got %h expected beef", render_data_r); end
    wait_ready();
  endtask

  // cur1 wr2 disp1: fill bank 2, rotate it back to write (cleared), then to current and read zeros
  task automatic test_clear();
    int cnt;
    for (int i = 0; i < 16; i++) write_word(AW'(i), 16'hA000 | WS'(i));
    do_swap();
    checks++; if (cur_bank_out !== 2'd2) begin errors++; $display("FAIL clr_cur_a: got %0d expected 2", cur_bank_out); end
    wait_ready();
    swap_req_in = 1'b1;
    #1;
    tick();
    swap_req_in = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40 && !ready_out; n++) begin
      cnt++;
      logic_wr_en  = (n == 8);
      logic_addr_w = 4'd3;
      logic_data_w = 16'h1234;
      tick();
    end
    logic_wr_en = 1'b0;
    checks++; if (cnt != 16) begin errors++; $display("FAIL clr_ready_low_cycles: got %0d expected 16", cnt); end
    checks++; if (cur_bank_out !== 2'd0) begin errors++; $display("FAIL clr_cur_b: got %0d expected 0", cur_bank_out); end
    do_swap();
    checks++; if (cur_bank_out !== 2'd2) begin errors++; $display("FAIL clr_cur_c: got %0d expected 2", cur_bank_out); end
    for (int i = 0; i < 16; i++) begin
      logic_addr_r = AW'(i);
      tick();
      tick();
      checks++;
      if (logic_data_r !== 16'h0) begin
        errors++;
        $display("FAIL clr_word_zero addr %0d: got %h expected 0000", i, logic_data_r);
      end
    end
    wait_ready();
  endtask

  // cur2 wr0 disp1: hold request across CLEAR, second ack lands on first IDLE cycle
  task automatic test_held_swap();
    int cnt;
    swap_req_in = 1'b1;
    #1;
    checks++; if (swap_ack_out !== 1'b1) begin errors++; $display("FAIL held_first_ack: got %0b expected 1", swap_ack_out); end
    tick();
    cnt = 0;
    for (int n = 0; n < 40 && !swap_ack_out; n++) begin
      cnt++;
      tick();
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL held_ack_gap: got %0d expected 16", cnt); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL held_ack_in_idle: ready got %0b expected 1", ready_out); end
    checks++; if (cur_bank_out !== 2'd0) begin errors++; $display("FAIL held_cur_mid: got %0d expected 0", cur_bank_out); end
    tick();
    swap_req_in = 1'b0;
    checks++; if (cur_bank_out !== 2'd2) begin errors++; $display("FAIL held_cur_final: got %0d expected 2", cur_bank_out); end
    wait_ready();
    write_word(4'd2, 16'h7777);
    do_swap();
    logic_addr_r = 4'd2;
    tick();
    tick();
    checks++; if (logic_data_r !== 16'h7777) begin errors++; $display("FAIL held_wr_lowest: got %h expected 7777", logic_data_r); end
    wait_ready();
  endtask

  // From reset (cur0 wr1 disp0): simultaneous swap and frame
  task automatic test_swap_frame();
    apply_reset();
    swap_req_in = 1'b1;
    render_frame_in = 1'b1;
    #1;
    checks++; if (swap_ack_out !== 1'b1) begin errors++; $display("FAIL sf_ack: got %0b expected 1", swap_ack_out); end
    tick();
    swap_req_in = 1'b0;
    render_frame_in = 1'b0;
    checks++; if (cur_bank_out !== 2'd1) begin errors++; $display("FAIL sf_cur: got %0d expected 1", cur_bank_out); end
    checks++; if (disp_bank_out !== 2'd0) begin errors++; $display("FAIL sf_disp: got %0d expected 0", disp_bank_out); end
    wait_ready();
    write_word(4'd7, 16'h3333);
    do_swap();
    checks++; if (cur_bank_out !== 2'd2) begin errors++; $display("FAIL sf_cur_next: got %0d expected 2", cur_bank_out); end
    logic_addr_r = 4'd7;
    tick();
    tick();
    checks++; if (logic_data_r !== 16'h3333) begin errors++; $display("FAIL sf_wr_was_2: got %h expected 3333", logic_data_r); end
    wait_ready();
  endtask

  // cur2 wr1 disp0: address captured with old bank select just as the swap lands
  task automatic test_registered_select();
    write_word(4'd7, 16'h5555);
    logic_addr_r = 4'd7;
    swap_req_in = 1'b1;
    tick();
    swap_req_in = 1'b0;
    tick();
    checks++; if (logic_data_r !== 16'h3333) begin errors++; $display("FAIL rs_pre_swap_bank: got %h expected 3333", logic_data_r); end
    tick();
    checks++; if (logic_data_r !== 16'h5555) begin errors++; $display("FAIL rs_post_swap_bank: got %h expected 5555", logic_data_r); end
    checks++; if (cur_bank_out !== 2'd1) begin errors++; $display("FAIL rs_cur: got %0d expected 1", cur_bank_out); end
  endtask

  // Still in CLEAR from the previous swap
  task automatic test_reset_mid_clear();
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL rmc_in_clear: ready got %0b expected 0", ready_out); end
    render_frame_in = 1'b1;
    tick();
    render_frame_in = 1'b0;
    checks++; if (disp_bank_out !== 2'd1) begin errors++; $display("FAIL rmc_frame_in_clear: disp got %0d expected 1", disp_bank_out); end
    swap_req_in = 1'b1;
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL rmc_ready: got %0b expected 0", ready_out); end
    checks++; if (swap_ack_out !== 1'b0) begin errors++; $display("FAIL rmc_ack: got %0b expected 0", swap_ack_out); end
    checks++; if (cur_bank_out !== 2'd0) begin errors++; $display("FAIL rmc_cur: got %0d expected 0", cur_bank_out); end
    checks++; if (disp_bank_out !== 2'd0) begin errors++; $display("FAIL rmc_disp: got %0d expected 0", disp_bank_out); end
    swap_req_in = 1'b0;
    #1;
    rst_n_in = 1'b1;
    #1;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL rmc_release_ready: got %0b expected 0", ready_out); end
    tick();
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rmc_ready_next: got %0b expected 1", ready_out); end
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_clear();
    test_held_swap();
    test_swap_frame();
    test_registered_select();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_buffer.md
Name: multi_buffer

Overview:
- Parametrised N-bank frame store for the life engine, successor to the two-bank ping-pong store.
- The logic engine reads generation k from the "current" bank and writes generation k+1 into the "write" bank.
- The renderer reads a separate "display" bank that only changes at a render frame boundary, so the display never tears.
- Swaps use a request/acknowledge handshake. An optional clear engine zeroes the newly assigned write bank after every swap.

Parameters:
WORD_SIZE, 16, bits per memory word
DEPTH, 4096, words per bank; AW = $clog2(DEPTH)
NUM_BANKS, 3, bank count; must be >= 3 (elaboration error otherwise)
CLEAR_ON_SWAP, 1, 1 = zero the new write bank after each accepted swap

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
swap_req_in  in  1  level; logic engine has finished the write bank; held until ack
swap_ack_out  out  1  one-cycle pulse; swap accepted this cycle
render_frame_in  in  1  one-cycle pulse at render frame start
render_addr_r  in  AW  render read address (display bank)
logic_addr_r  in  AW  logic read address (current bank)
logic_addr_w  in  AW  logic write address (write bank)
logic_data_w  in  WORD_SIZE  logic write data
logic_wr_en  in  1  logic write strobe
ready_out  out  1  high when IDLE; writes and swaps accepted
render_data_r  out  WORD_SIZE  render read data
logic_data_r  out  WORD_SIZE  logic read data
cur_bank_out  out  $clog2(NUM_BANKS)  current bank index
disp_bank_out  out  $clog2(NUM_BANKS)  display bank index

Behaviour:
- Memories: NUM_BANKS inferred dual-port RAMs, 1-cycle read. Contents are not reset.
- Bank indices and reset values:
  - wr_idx = 1, cur_idx = 0, disp_idx = 0.
  - FSM = IDLE, swap_ack_out = 0, ready_out = 0; ready_out asserts on the first clock after rst_n_in deasserts.
  - render_data_r and logic_data_r reset to 0.
- Invariant: wr_idx differs from both cur_idx and disp_idx at all times.
- Read latency is 2 cycles: address -> RAM (cycle 1) -> output register (cycle 2).
  - The bank-select for each read port is registered alongside its address.
  - Data always comes from the bank that was selected when the address was presented, even across a swap or frame event.
- Writes:
  - Go to wr_idx only when logic_wr_en = 1 and state = IDLE.
  - logic_wr_en in CLEAR state is ignored (dropped, no error).
- Display update: a render_frame_in pulse sets disp_idx <= cur_idx, using the pre-update cur_idx.
- Swap acceptance, when state = IDLE and swap_req_in = 1:
  - swap_ack_out = 1 for one cycle.
  - cur_idx <= wr_idx.
  - wr_idx <= lowest index not equal to the old wr_idx and not equal to disp_next, where disp_next = render_frame_in ? old cur_idx : disp_idx.
  - A simultaneous swap and render_frame_in is legal: the display takes the old current bank and the new write bank avoids it.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on an accepted swap when CLEAR_ON_SWAP = 1. Otherwise the FSM stays in IDLE.
  - In CLEAR, a counter clr_addr runs 0..DEPTH-1 writing 0 to wr_idx, one word per cycle. ready_out = 0.
  - CLEAR -> IDLE in the cycle after the write to DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
  - swap_req_in during CLEAR is not acknowledged; the request stays pending and is acked in the first IDLE cycle.
  - render_frame_in during CLEAR is honoured normally and reads continue.
- Reset mid-CLEAR: FSM returns to IDLE and indices return to their reset values. The bank is left partially cleared; no recovery is attempted.
- swap_ack_out never asserts on two consecutive cycles when CLEAR_ON_SWAP = 1.

Test Plan:
1. Reset, then write 0xBEEF at address 5 (bank 1), request swap -> ack pulse, cur = 1, wr = 2. logic_addr_r = 5 returns 0xBEEF 2 cycles later. render_addr_r = 5 still reads bank 0 until render_frame_in, then 0xBEEF.
2. CLEAR_ON_SWAP = 1, DEPTH = 16: swap -> ready_out low for exactly 16 cycles. All 16 words of the new write bank read 0 afterwards. A logic_wr_en issued during CLEAR leaves memory unchanged.
3. swap_req_in and render_frame_in in the same cycle with cur = 0, wr = 1, disp = 0 -> disp = 0, cur = 1, wr = 2. The invariant holds.
4. swap_req_in held high through CLEAR -> a second ack arrives in the first IDLE cycle, not earlier. Indices rotate to cur = 2 and wr = the lowest free index.
5. Address presented, then a swap on the next edge -> returned data comes from the pre-swap bank (registered select).
6. rst_n_in asserted mid-CLEAR with no clock edge -> ready_out = 0, swap_ack_out = 0 and indices 1/0/0 immediately; after deassert ready_out rises next cycle.
